// File: rtl/gpu_pkg.sv
// Shared GPU ALU-path definitions: opcode, line FSM states,
// and the internal width rule for the Bresenham datapath.
package gpu_pkg;

    localparam logic [2:0] OPCODE_LINE = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_t;

    // Two guard bits keep err and 2*err from overflowing at range extremes.
    function automatic int line_w(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: absolute deltas,
// step directions and the initial error term.
module line_setup
    import gpu_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int W  = 11
) (
    input  logic signed [XW-1:0] x0,
    input  logic signed [XW-1:0] x1,
    input  logic signed [YW-1:0] y0,
    input  logic signed [YW-1:0] y1,
    output logic signed [W-1:0]  dx,
    output logic signed [W-1:0]  dy,
    output logic signed [W-1:0]  err,
    output logic                 sx_neg,
    output logic                 sy_neg
);

    logic signed [W-1:0] xd;
    logic signed [W-1:0] yd;

    always_comb begin
        xd = {{(W-XW){x1[XW-1]}}, x1} - {{(W-XW){x0[XW-1]}}, x0};
        yd = {{(W-YW){y1[YW-1]}}, y1} - {{(W-YW){y0[YW-1]}}, y0};
        dx = xd[W-1] ? -xd : xd;
        dy = yd[W-1] ? yd : -yd;
        err = dx + dy;
        sx_neg = !(x1 > x0);
        sy_neg = !(y1 > y0);
    end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: command handshake in,
// one pixel per accepted step out, with abort and done pulse.
module line_raster
    import gpu_pkg::*;
#(
    parameter int XW  = 9,
    parameter int YW  = 8,
    parameter int OPW = 3,
    parameter logic [OPW-1:0] OPCODE = OPW'(OPCODE_LINE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPW-1:0]       ctrl_ALU,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic signed [XW-1:0] x0,
    input  logic signed [XW-1:0] x1,
    input  logic signed [YW-1:0] y0,
    input  logic signed [YW-1:0] y1,
    input  logic                 abort,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic signed [XW-1:0] pix_x,
    output logic signed [YW-1:0] pix_y,
    output logic                 pix_last,
    output logic                 busy,
    output logic                 done
);

    localparam int W = line_w(XW, YW);

    state_t state;

    logic signed [XW-1:0] x0_q, x1_q;
    logic signed [YW-1:0] y0_q, y1_q;
    logic signed [W-1:0]  dx_q, dy_q, err_q;
    logic                 sx_neg_q, sy_neg_q;

    logic signed [W-1:0]  s_dx, s_dy, s_err;
    logic                 s_sx_neg, s_sy_neg;

    line_setup #(
        .XW(XW),
        .YW(YW),
        .W (W)
    ) u_setup (
        .x0    (x0_q),
        .x1    (x1_q),
        .y0    (y0_q),
        .y1    (y1_q),
        .dx    (s_dx),
        .dy    (s_dy),
        .err   (s_err),
        .sx_neg(s_sx_neg),
        .sy_neg(s_sy_neg)
    );

    logic signed [W:0]    e2, dx_e, dy_e;
    logic                 step_x, step_y;
    logic signed [W-1:0]  nerr;
    logic signed [XW-1:0] nx;
    logic signed [YW-1:0] ny;

    always_comb begin
        e2     = {err_q, 1'b0};
        dx_e   = {dx_q[W-1], dx_q};
        dy_e   = {dy_q[W-1], dy_q};
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        nerr   = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
        nx     = pix_x;
        ny     = pix_y;
        if (step_x)
            nx = sx_neg_q ? pix_x - XW'(1) : pix_x + XW'(1);
        if (step_y)
            ny = sy_neg_q ? pix_y - YW'(1) : pix_y + YW'(1);
    end

    // Depends on ctrl_ALU directly so acceptance needs no extra cycle.
    assign cmd_ready = reset && (state == IDLE) && (ctrl_ALU == OPCODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_last  <= 1'b0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        x0_q  <= x0;
                        x1_q  <= x1;
                        y0_q  <= y0;
                        y1_q  <= y1;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        dx_q      <= s_dx;
                        dy_q      <= s_dy;
                        err_q     <= s_err;
                        sx_neg_q  <= s_sx_neg;
                        sy_neg_q  <= s_sy_neg;
                        pix_x     <= x0_q;
                        pix_y     <= y0_q;
                        pix_last  <= (x0_q == x1_q) && (y0_q == y1_q);
                        pix_valid <= 1'b1;
                        state     <= DRAW;
                    end
                end
                DRAW: begin
                    if (abort) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (pix_ready) begin
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            err_q    <= nerr;
                            pix_x    <= nx;
                            pix_y    <= ny;
                            pix_last <= (nx == x1_q) && (ny == y1_q);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Directed self-checking bench for line_raster.
// Inputs change after negedge; outputs are sampled at negedge.
module tb_line_raster;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        ctrl_ALU;
    logic              cmd_valid;
    logic              cmd_ready;
    logic signed [8:0] x0, x1;
    logic signed [7:0] y0, y1;
    logic              abort;
    logic              pix_valid;
    logic              pix_ready;
    logic signed [8:0] pix_x;
    logic signed [7:0] pix_y;
    logic              pix_last;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic signed [8:0] cap_x[$];
    logic signed [7:0] cap_y[$];
    logic              cap_last[$];

    always #5 clk = ~clk;

    line_raster dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl_ALU (ctrl_ALU),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .x0       (x0),
        .x1       (x1),
        .y0       (y0),
        .y1       (y1),
        .abort    (abort),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_last (pix_last),
        .busy     (busy),
        .done     (done)
    );

    // Stimulus only: presents a command for one cycle, returns at negedge in SETUP.
    task automatic send_cmd(input int ax0, input int ay0, input int ax1, input int ay1);
        @(negedge clk);
        ctrl_ALU  = 3'b100;
        x0        = 9'(ax0);
        y0        = 8'(ay0);
        x1        = 9'(ax1);
        y1        = 8'(ay1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Stimulus only: collects pixels with pix_ready held high.
    task automatic capture(input int budget, output bit timeout,
                           output int first, output logic done_after);
        cap_x.delete();
        cap_y.delete();
        cap_last.delete();
        timeout    = 1'b1;
        first      = -1;
        done_after = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                if (first < 0) first = c;
                cap_x.push_back(pix_x);
                cap_y.push_back(pix_y);
                cap_last.push_back(pix_last);
                if (pix_last) begin
                    timeout = 1'b0;
                    @(negedge clk);
                    done_after = done;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ctrl_ALU = 3'b100;
        cmd_valid = 1'b0;
        abort = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, pix_valid, pix_last, busy, done} !== 5'b0 ||
            pix_x !== 9'sd0 || pix_y !== 8'sd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b b=%b d=%b x=%0d y=%0d want all 0",
                     cmd_ready, pix_valid, pix_last, busy, done, pix_x, pix_y);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_horizontal;
        bit timeout; int first; logic d;
        bit ok;
        send_cmd(0, 0, 5, 0);
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL horiz_setup: got v=%b busy=%b rdy=%b want 0 1 0",
                     pix_valid, busy, cmd_ready);
        end
        capture(20, timeout, first, d);
        checks++;
        if (timeout || first !== 0) begin
            failures++;
            $display("FAIL horiz_latency: got first=%0d timeout=%b want 0 0", first, timeout);
        end
        ok = (cap_x.size() == 6);
        for (int i = 0; i < cap_x.size() && ok; i++)
            if (cap_x[i] !== 9'(i) || cap_y[i] !== 8'sd0 || cap_last[i] !== (i == 5))
                ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL horiz_seq: got %0d pixels want x=0..5 y=0 last on 5", cap_x.size());
        end
        checks++;
        if (d !== 1'b1 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL horiz_done: got done=%b v=%b want 1 0", d, pix_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL horiz_idle: got done=%b busy=%b rdy=%b want 0 0 1",
                     done, busy, cmd_ready);
        end
    endtask

    task automatic test_steep;
        bit timeout; int first; logic d; bit ok;
        int ex[6] = '{0, 0, 1, 1, 2, 2};
        int ey[6] = '{0, 1, 2, 3, 4, 5};
        send_cmd(0, 0, 2, 5);
        capture(20, timeout, first, d);
        ok = !timeout && (cap_x.size() == 6);
        for (int i = 0; i < cap_x.size() && ok; i++)
            if (cap_x[i] !== 9'(ex[i]) || cap_y[i] !== 8'(ey[i])) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL steep_seq: got %0d pixels timeout=%b want 6 in order",
                     cap_x.size(), timeout);
        end
        checks++;
        if (d !== 1'b1) begin
            failures++;
            $display("FAIL steep_done: got %b want 1", d);
        end
    endtask

    task automatic test_negative;
        bit timeout; int first; logic d; bit ok;
        int ex[6] = '{3, 2, 1, 0, -1, -2};
        int ey[6] = '{3, 3, 2, 2, 1, 1};
        send_cmd(3, 3, -2, 1);
        capture(20, timeout, first, d);
        ok = !timeout && (cap_x.size() == 6);
        for (int i = 0; i < cap_x.size() && ok; i++)
            if (cap_x[i] !== 9'(ex[i]) || cap_y[i] !== 8'(ey[i])) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL neg_seq: got %0d pixels timeout=%b want 6 in order",
                     cap_x.size(), timeout);
        end
        checks++;
        if (d !== 1'b1) begin
            failures++;
            $display("FAIL neg_done: got %b want 1", d);
        end
    endtask

    task automatic test_point_and_gate;
        bit timeout; int first; logic d; bit bad;
        send_cmd(-7, 4, -7, 4);
        capture(10, timeout, first, d);
        checks++;
        if (timeout || cap_x.size() != 1 || cap_x[0] !== -9'sd7 ||
            cap_y[0] !== 8'sd4 || cap_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL point_pixel: got n=%0d timeout=%b want one (-7,4) last=1",
                     cap_x.size(), timeout);
        end
        checks++;
        if (d !== 1'b1) begin
            failures++;
            $display("FAIL point_done: got %b want 1", d);
        end
        @(negedge clk);
        ctrl_ALU = 3'b011;
        cmd_valid = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            #1;
            if (cmd_ready !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ctrl_ALU = 3'b100;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL opcode_gate: got activity with ctrl_ALU=011 want none");
        end
    endtask

    task automatic test_backpressure;
        int ex[5] = '{0, 1, 2, 3, 4};
        int ey[5] = '{0, 1, 1, 2, 2};
        bit stalled, unstable, finished, ok;
        logic signed [8:0] hx;
        logic signed [7:0] hy;
        logic hl;
        cap_x.delete();
        cap_y.delete();
        stalled = 1'b0;
        unstable = 1'b0;
        finished = 1'b0;
        send_cmd(0, 0, 4, 2);
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            if (stalled && (pix_valid !== 1'b1 || pix_x !== hx ||
                            pix_y !== hy || pix_last !== hl))
                unstable = 1'b1;
            pix_ready = 1'($urandom_range(0, 1));
            if (pix_valid && pix_ready) begin
                cap_x.push_back(pix_x);
                cap_y.push_back(pix_y);
                if (pix_last) finished = 1'b1;
            end
            stalled = pix_valid && !pix_ready;
            hx = pix_x;
            hy = pix_y;
            hl = pix_last;
        end
        pix_ready = 1'b1;
        ok = finished && (cap_x.size() == 5);
        for (int i = 0; i < cap_x.size() && ok; i++)
            if (cap_x[i] !== 9'(ex[i]) || cap_y[i] !== 8'(ey[i])) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_seq: got %0d pixels finished=%b want 5 in order",
                     cap_x.size(), finished);
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL bp_stable: outputs changed during stall want held");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort_and_reset;
        bit seen, dpulse;
        send_cmd(0, 0, 5, 0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pix_valid && pix_x === 9'sd2) begin
                abort = 1'b1;
                seen = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (!seen || pix_valid !== 1'b0 || done !== 1'b0 ||
            cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_mid: got seen=%b v=%b done=%b rdy=%b busy=%b want 1 0 0 1 0",
                     seen, pix_valid, done, cmd_ready, busy);
        end
        send_cmd(1, 1, 1, 1);
        @(negedge clk);
        abort = 1'b1;
        checks++;
        if (pix_valid !== 1'b1 || pix_last !== 1'b1) begin
            failures++;
            $display("FAIL abort_last_pixel: got v=%b l=%b want 1 1", pix_valid, pix_last);
        end
        dpulse = 1'b0;
        repeat (3) begin
            @(negedge clk);
            abort = 1'b0;
            if (done !== 1'b0) dpulse = 1'b1;
        end
        checks++;
        if (dpulse || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_last_nodone: got done_seen=%b v=%b want 0 0", dpulse, pix_valid);
        end
        pix_ready = 1'b0;
        send_cmd(0, 0, 5, 5);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({pix_valid, pix_last, busy, done, cmd_ready} !== 5'b0 ||
            pix_x !== 9'sd0 || pix_y !== 8'sd0) begin
            failures++;
            $display("FAIL async_reset: got v=%b l=%b b=%b d=%b rdy=%b x=%0d y=%0d want 0",
                     pix_valid, pix_last, busy, done, cmd_ready, pix_x, pix_y);
        end
        @(negedge clk);
        reset = 1'b1;
        pix_ready = 1'b1;
        dpulse = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || pix_valid !== 1'b0) dpulse = 1'b1;
        end
        checks++;
        if (dpulse || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard: got activity=%b rdy=%b want 0 1", dpulse, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_negative();
        test_point_and_gate();
        test_backpressure();
        test_abort_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Parametrised Bresenham line rasteriser; successor to the current line-draw unit in the GPU ALU path.
- Accepts a segment (x0,y0)->(x1,y1) through a valid/ready command handshake when the ALU op select matches OPCODE.
- Emits exactly one pixel per step on a valid/ready pixel stream with backpressure. Handles any slope and direction with true Bresenham error stepping, not the diagonal-then-straight walk.
- Flags the final pixel, pulses done, and supports abort.

Parameters:
- XW, 9, signed x-coordinate width.
- YW, 8, signed y-coordinate width.
- OPW, 3, width of ctrl_ALU.
- OPCODE, 3'b100, ctrl_ALU value that enables command acceptance.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ctrl_ALU  in  OPW  ALU op select; commands are accepted only when equal to OPCODE.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- x0, x1  in  XW  signed start/end x.
- y0, y1  in  YW  signed start/end y.
- abort  in  1  synchronous kill of the in-flight line.
- pix_valid  out  1  pix_x/pix_y valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_x  out  XW  signed pixel x.
- pix_y  out  YW  signed pixel y.
- pix_last  out  1  current pixel is the endpoint.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (reset==0, async): state=IDLE; cmd_ready, pix_valid, pix_last, busy, done = 0; pix_x, pix_y = 0; internal registers = 0. Reset mid-line discards the line with no done pulse.
- FSM states:
  - IDLE: cmd_ready = (ctrl_ALU==OPCODE). A handshake (cmd_valid && cmd_ready) latches x0,y0,x1,y1 and goes to SETUP.
  - SETUP (1 cycle):
    - W = max(XW,YW)+2; all differences are computed sign-extended to W.
    - dx = |x1-x0|, dy = -|y1-y0|, sx = (x1>x0)?+1:-1, sy = (y1>y0)?+1:-1.
    - err = dx+dy; cur = (x0,y0).
    - Go to DRAW.
  - DRAW:
    - pix_valid=1, pix_x/pix_y = cur, pix_last = (cur==(x1,y1)).
    - On pix_valid && pix_ready && !pix_last, with e2 = 2*err (width W+1):
      - if e2>=dy then err+=dy and x+=sx;
      - if e2<=dx then err+=dx and y+=sy;
      - both updates apply in the same cycle.
    - On handshake with pix_last: go to DONE.
  - DONE (1 cycle): done=1, pix_valid=0. Next state is IDLE.
- Latency: command accepted at cycle N -> first pix_valid at N+2. While pix_ready stays high, one pixel per cycle. Total pixels = max(dx,-dy)+1.
- Backpressure: while pix_valid && !pix_ready, pix_x, pix_y and pix_last hold stable and no stepping occurs.
- Degenerate point (x0==x1, y0==y1): exactly one pixel, with pix_last=1.
- Horizontal, vertical and 45-degree lines need no special case; the same equations apply.
- ctrl_ALU: gates acceptance only. Changing it mid-line does not stall or alter an in-flight line.
- cmd_ready = 0 in SETUP, DRAW and DONE; there is no command queueing.
- abort:
  - Sampled in SETUP or DRAW: next state IDLE, pix_valid drops the following cycle, no done pulse.
  - Abort and the last-pixel handshake in the same cycle: abort wins, so no done is issued; the pixel itself counts as transferred.
  - Abort in IDLE or DONE: no effect.
- All coordinate arithmetic is two's-complement. Endpoints anywhere in the signed XW/YW range are legal; internal width W prevents overflow of err and e2.

Decomposition:
- Shared package (gpu_pkg): OPCODE_LINE = 3'b100, the FSM state enum (IDLE, SETUP, DRAW, DONE), and the W width function.
- One natural sub-module: line_setup (combinational abs/sign/initial-err computation), instantiated once and registered into SETUP outputs.
- The stepping datapath and FSM stay in line_raster.

Test Plan:
1. Command (0,0)->(5,0), pix_ready=1: pixels x=0..5 with y=0, first pixel at N+2, pix_last on (5,0), done pulse one cycle after.
2. Steep line (0,0)->(2,5): exactly 6 pixels in order (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); then done.
3. Negative direction (3,3)->(-2,1): 6 pixels (3,3),(2,3),(1,2),(0,2),(-1,1),(-2,1); x and y never overshoot the endpoint.
4. Single point (-7,4)->(-7,4): one pixel with pix_last=1, then done. Separately, ctrl_ALU=3'b011 with cmd_valid=1 -> cmd_ready stays 0 and nothing is emitted.
5. Backpressure on (0,0)->(4,2): toggle pix_ready randomly -> pixel sequence identical to the pix_ready=1 run, and outputs stable throughout every stall.
6. Abort asserted while pixel 3 of 6 is presented -> pix_valid low the next cycle, no done, cmd_ready high again. Reset asserted mid-line -> all outputs 0 immediately (async).
